// File: rtl/cxs_rx_link_ctrl.sv
// cxs_rx_link_ctrl: CXS receive endpoint with activation FSM, credit issue and flit FIFO
module cxs_rx_link_ctrl #(
   parameter int CXS_DATA_FLIT_WIDTH = 256,
   parameter int CXS_CNTL_WIDTH = 14,
   parameter int MAX_CREDITS = 15
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cxs_active_req,
   output logic                           cxs_active_ack,
   output logic                           cxs_deact_hint,
   input  logic [CXS_DATA_FLIT_WIDTH-1:0] cxs_data,
   input  logic [CXS_CNTL_WIDTH-1:0]      cxs_cntl,
   input  logic                           cxs_valid,
   input  logic                           cxs_crdrtn,
   output logic                           cxs_crdgnt,
   input  logic                           deact_hint_req,
   output logic [CXS_DATA_FLIT_WIDTH-1:0] flit_data,
   output logic [CXS_CNTL_WIDTH-1:0]      flit_cntl,
   output logic                           flit_valid,
   input  logic                           flit_ready,
   output logic [3:0]                     credits_out,
   output logic [1:0]                     link_state,
   output logic                           proto_err
);
   localparam int FW = CXS_DATA_FLIT_WIDTH + CXS_CNTL_WIDTH;
   localparam int AW = MAX_CREDITS > 1 ? $clog2(MAX_CREDITS) : 1;
   typedef enum logic [1:0] {STOP, ACTIVATE, RUN, DEACTIVATE} state_t;
   state_t state;
   logic [FW-1:0] mem [2**AW];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [3:0] count;
   logic [4:0] cred_add, cred_sub, grant_sum;
   logic push, pop, wr_en, full, room, idle, bad;
   assign link_state = state;
   assign flit_valid = count != 4'd0;
   assign pop = flit_valid & flit_ready;
   assign wr_en = cxs_valid & (credits_out != 4'd0);
   assign full = count == 4'(MAX_CREDITS);
   assign push = wr_en & (!full | pop);
   // Outstanding credits plus buffered flits plus the grant already on the wire bound the FIFO occupancy
   assign grant_sum = {1'b0, credits_out} + {1'b0, count} + {4'b0, cxs_crdgnt};
   assign room = grant_sum < 5'(MAX_CREDITS);
   assign idle = credits_out == 4'd0 && !cxs_valid && !cxs_crdrtn;
   assign cred_add = {1'b0, credits_out} + {4'b0, cxs_crdgnt};
   assign cred_sub = {4'b0, cxs_valid} + {4'b0, cxs_crdrtn};
   assign bad = (cxs_valid & credits_out == 4'd0) | (state == STOP & (cxs_valid | cxs_crdrtn))
              | (cxs_crdrtn & credits_out == 4'd0) | (wr_en & full & !pop);
   assign {flit_cntl, flit_data} = flit_valid ? mem[rd_ptr] : '0;
   // Link FSM; ack, grant and hint are registered from the transition being taken
   always_ff @(posedge clk)
      if (reset) begin
         state <= STOP;
         cxs_active_ack <= 1'b0;
         cxs_crdgnt <= 1'b0;
         cxs_deact_hint <= 1'b0;
      end else
         case (state)
            STOP: begin
               state <= cxs_active_req ? ACTIVATE : STOP;
               cxs_active_ack <= 1'b0;
               cxs_crdgnt <= 1'b0;
               cxs_deact_hint <= 1'b0;
            end
            ACTIVATE: begin
               state <= RUN;
               cxs_active_ack <= 1'b1;
               cxs_crdgnt <= room;
               cxs_deact_hint <= deact_hint_req;
            end
            RUN: begin
               state <= cxs_active_req ? RUN : DEACTIVATE;
               cxs_active_ack <= 1'b1;
               cxs_crdgnt <= cxs_active_req & room;
               cxs_deact_hint <= cxs_active_req & deact_hint_req;
            end
            default: begin
               state <= idle ? STOP : DEACTIVATE;
               cxs_active_ack <= !idle;
               cxs_crdgnt <= 1'b0;
               cxs_deact_hint <= 1'b0;
            end
         endcase
   // Credit accounting (saturating at zero), FIFO pointers and sticky protocol error
   always_ff @(posedge clk)
      if (reset) begin
         credits_out <= 4'd0;
         count <= 4'd0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         proto_err <= 1'b0;
      end else begin
         credits_out <= cred_add > cred_sub ? 4'(cred_add - cred_sub) : 4'd0;
         count <= count + 4'(push) - 4'(pop);
         if (push) wr_ptr <= wr_ptr == AW'(MAX_CREDITS - 1) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr == AW'(MAX_CREDITS - 1) ? '0 : rd_ptr + 1'b1;
         if (bad) proto_err <= 1'b1;
      end
   // FIFO storage, no reset needed since reads are gated by the occupancy count
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {cxs_cntl, cxs_data};
endmodule
